// File: rtl/rtc_time_updater.sv
// RTC time updater: read-increment-write of packed BCD time registers.
// Optional weekday register is enabled with RTC_WEEKDAY_EN.
module rtc_time_updater #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_1hz,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  day_pulse,
  output logic                  overrun,
  output logic                  bcd_err
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
`ifdef RTC_WEEKDAY_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CALC,
    S_WRITE,
    S_NEXT
  } state_t;

  state_t state, state_n;

  logic [1:0]            idx, idx_n;
  logic                  carry, carry_n;
  logic                  pending, pend_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n;
  logic                  we_n;
  logic                  busy_n;
  logic                  dp_n;
  logic                  ovr_n;
  logic                  err_n;

  logic [DATA_WIDTH-1:0] lim;
  logic [DATA_WIDTH-1:0] minv;
  logic                  wday;
  logic [3:0]            hi;
  logic [3:0]            lo;
  logic                  illegal;
  logic [DATA_WIDTH-1:0] nv;
  logic                  cy;

  // Per-register limits and the BCD increment of the value just read.
  always_comb begin
    lim  = 8'h59;
    minv = 8'h00;
    wday = 1'b0;
    case (idx)
      2'd2: lim = 8'h23;
      2'd3: begin
        lim  = 8'h07;
        minv = 8'h01;
        wday = 1'b1;
      end
      default: ;
    endcase
    hi = mem_rdata[7:4];
    lo = mem_rdata[3:0];
    illegal = (hi > 4'd9) || (lo > 4'd9) || (mem_rdata > lim)
              || (wday && (mem_rdata == 8'h00));
    nv = minv;
    cy = 1'b0;
    if (illegal) begin
      nv = minv;
    end else if (mem_rdata == lim) begin
      nv = minv;
      cy = 1'b1;
    end else if (lo == 4'd9) begin
      nv = {hi + 4'd1, 4'd0};
    end else begin
      nv = {hi, lo + 4'd1};
    end
  end

  // Next-state, next-output and tick bookkeeping.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    carry_n = carry;
    pend_n  = pending;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    we_n    = 1'b0;
    busy_n  = busy;
    dp_n    = 1'b0;
    ovr_n   = overrun;
    err_n   = bcd_err;
    if (state != S_IDLE && tick_1hz) begin
      if (pending) ovr_n = 1'b1;
      else         pend_n = 1'b1;
    end
    case (state)
      S_IDLE: begin
        if (tick_1hz || pending) begin
          state_n = S_READ;
          idx_n   = 2'd0;
          addr_n  = BASE;
          busy_n  = 1'b1;
          pend_n  = pending && tick_1hz;
        end
      end
      S_READ: state_n = S_CALC;
      S_CALC: begin
        state_n = S_WRITE;
        we_n    = 1'b1;
        wdata_n = nv;
        carry_n = cy;
        if (illegal) err_n = 1'b1;
        dp_n    = (idx == 2'd2) && cy;
      end
      S_WRITE: state_n = S_NEXT;
      S_NEXT: begin
        if (carry && (idx < LAST_IDX)) begin
          state_n = S_READ;
          idx_n   = idx + 2'd1;
          addr_n  = BASE + ADDR_WIDTH'(idx + 2'd1);
        end else begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= 2'd0;
      carry     <= 1'b0;
      pending   <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      day_pulse <= 1'b0;
      overrun   <= 1'b0;
      bcd_err   <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      carry     <= carry_n;
      pending   <= pend_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      mem_we    <= we_n;
      busy      <= busy_n;
      day_pulse <= dp_n;
      overrun   <= ovr_n;
      bcd_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_rtc_time_updater.sv
// Directed bench for rtc_time_updater with a registered-read RAM model.
// Expectations follow RTC_WEEKDAY_EN when it is defined.
module tb_rtc_time_updater;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       day_pulse;
  logic       overrun;
  logic       bcd_err;

  int checks = 0;
  int passed = 0;

`ifdef RTC_WEEKDAY_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  rtc_time_updater #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8),
    .BASE_ADDR(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick_1hz(tick_1hz),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .busy(busy),
    .day_pulse(day_pulse),
    .overrun(overrun),
    .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [16];
  logic       pre_we = 1'b0;
  logic [3:0] pre_addr = 4'd0;
  logic [7:0] pre_data = 8'd0;

  // RAM: write commits at the edge, read data registered.
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int wr_cnt [16];
  int a1_cnt = 0;
  int a3_cnt = 0;
  int dp_cnt = 0;
  int we2_cnt = 0;
  logic we_prev = 1'b0;

  // Bus activity log.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_cnt[mem_addr] = wr_cnt[mem_addr] + 1;
      if (we_prev) we2_cnt = we2_cnt + 1;
    end
    we_prev = mem_we;
    if (busy && mem_addr == 4'd1) a1_cnt = a1_cnt + 1;
    if (busy && mem_addr == 4'd3) a3_cnt = a3_cnt + 1;
    if (day_pulse) dp_cnt = dp_cnt + 1;
  end

  task automatic poke(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    pre_addr = a;
    pre_data = d;
    pre_we = 1'b1;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  task automatic tick_once();
    @(posedge clk);
    #1 tick_1hz = 1'b1;
    @(posedge clk);
    #1 tick_1hz = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) return;
      n++;
    end
    n = -1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      pre_addr = 4'(i);
      pre_data = 8'h00;
      pre_we = 1'b1;
      @(posedge clk);
      #1;
    end
    pre_we = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_addr !== 4'd0)
      $display("FAIL reset_addr got %h want 0", mem_addr);
    else passed++;
    checks++;
    if (mem_wdata !== 8'd0 || mem_we !== 1'b0)
      $display("FAIL reset_write got %h/%b want 00/0", mem_wdata, mem_we);
    else passed++;
    checks++;
    if (busy !== 1'b0 || day_pulse !== 1'b0)
      $display("FAIL reset_busy got %b/%b want 0/0", busy, day_pulse);
    else passed++;
    checks++;
    if (overrun !== 1'b0 || bcd_err !== 1'b0)
      $display("FAIL reset_flags got %b/%b want 0/0", overrun, bcd_err);
    else passed++;
  endtask

  task automatic test_seconds();
    int w0, a1;
    logic [4:0] bp, wp;
    poke(4'd0, 8'h08);
    poke(4'd1, 8'h00);
    w0 = wr_cnt[0];
    a1 = a1_cnt;
    tick_once();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bp[i] = busy;
      wp[i] = mem_we;
    end
    checks++;
    if (bp !== 5'b01111)
      $display("FAIL sec_busy got %b want 01111", bp);
    else passed++;
    checks++;
    if (wp !== 5'b00100)
      $display("FAIL sec_we_timing got %b want 00100", wp);
    else passed++;
    checks++;
    if (ram[0] !== 8'h09 || wr_cnt[0] - w0 !== 1)
      $display("FAIL sec_value got %h/%0d want 09/1", ram[0], wr_cnt[0] - w0);
    else passed++;
    checks++;
    if (a1_cnt - a1 !== 0 || ram[1] !== 8'h00)
      $display("FAIL sec_no_min got %0d/%h want 0/00", a1_cnt - a1, ram[1]);
    else passed++;
  endtask

  task automatic test_min_carry();
    int n, w2;
    poke(4'd0, 8'h59);
    poke(4'd1, 8'h09);
    poke(4'd2, 8'h05);
    w2 = wr_cnt[2];
    tick_once();
    wait_idle(n);
    checks++;
    if (n !== 8)
      $display("FAIL min_busy got %0d want 8", n);
    else passed++;
    checks++;
    if (ram[0] !== 8'h00 || ram[1] !== 8'h10)
      $display("FAIL min_value got %h:%h want 10:00", ram[1], ram[0]);
    else passed++;
    checks++;
    if (ram[2] !== 8'h05 || wr_cnt[2] - w2 !== 0)
      $display("FAIL min_hours got %h/%0d want 05/0", ram[2], wr_cnt[2] - w2);
    else passed++;
  endtask

  task automatic test_day_wrap();
    int n, w3, a3, dp;
    poke(4'd0, 8'h59);
    poke(4'd1, 8'h59);
    poke(4'd2, 8'h23);
    poke(4'd3, 8'h07);
    w3 = wr_cnt[3];
    a3 = a3_cnt;
    dp = dp_cnt;
    tick_once();
    wait_idle(n);
    checks++;
    if (n !== (WD ? 16 : 12))
      $display("FAIL day_busy got %0d want %0d", n, WD ? 16 : 12);
    else passed++;
    checks++;
    if (ram[0] !== 8'h00 || ram[1] !== 8'h00 || ram[2] !== 8'h00)
      $display("FAIL day_time got %h:%h:%h want 00:00:00",
               ram[2], ram[1], ram[0]);
    else passed++;
    checks++;
    if (ram[3] !== (WD ? 8'h01 : 8'h07) || wr_cnt[3] - w3 !== (WD ? 1 : 0))
      $display("FAIL day_wday got %h/%0d want %h/%0d", ram[3],
               wr_cnt[3] - w3, WD ? 8'h01 : 8'h07, WD ? 1 : 0);
    else passed++;
    checks++;
    if (!WD && a3_cnt - a3 !== 0)
      $display("FAIL day_addr3 got %0d want 0", a3_cnt - a3);
    else passed++;
    checks++;
    if (dp_cnt - dp !== 1)
      $display("FAIL day_pulse got %0d want 1", dp_cnt - dp);
    else passed++;
  endtask

  task automatic test_bcd_err();
    int n, a1;
    poke(4'd0, 8'h5A);
    poke(4'd1, 8'h33);
    a1 = a1_cnt;
    tick_once();
    wait_idle(n);
    checks++;
    if (n !== 4 || ram[0] !== 8'h00)
      $display("FAIL bcd_fix got %0d/%h want 4/00", n, ram[0]);
    else passed++;
    checks++;
    if (bcd_err !== 1'b1)
      $display("FAIL bcd_flag got %b want 1", bcd_err);
    else passed++;
    checks++;
    if (ram[1] !== 8'h33 || a1_cnt - a1 !== 0)
      $display("FAIL bcd_no_min got %h/%0d want 33/0", ram[1], a1_cnt - a1);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int n, b;
    do_reset();
    poke(4'd0, 8'h59);
    poke(4'd1, 8'h59);
    poke(4'd2, 8'h23);
    poke(4'd3, 8'h07);
    @(posedge clk);
    #1 tick_1hz = 1'b1;
    repeat (3) @(posedge clk);
    #1 tick_1hz = 1'b0;
    wait_idle(n);
    checks++;
    if (n !== (WD ? 14 : 10))
      $display("FAIL b2b_first got %0d want %0d", n, WD ? 14 : 10);
    else passed++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1)
      $display("FAIL b2b_restart got %b want 1", busy);
    else passed++;
    wait_idle(n);
    checks++;
    if (n !== 3)
      $display("FAIL b2b_second got %0d want 3", n);
    else passed++;
    checks++;
    if (ram[0] !== 8'h01 || ram[1] !== 8'h00 || ram[2] !== 8'h00)
      $display("FAIL b2b_time got %h:%h:%h want 00:00:01",
               ram[2], ram[1], ram[0]);
    else passed++;
    checks++;
    if (overrun !== 1'b1)
      $display("FAIL b2b_overrun got %b want 1", overrun);
    else passed++;
    b = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) b++;
    end
    checks++;
    if (b !== 0)
      $display("FAIL b2b_dropped got %0d want 0", b);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int w1;
    do_reset();
    poke(4'd0, 8'h59);
    poke(4'd1, 8'h59);
    poke(4'd2, 8'h12);
    w1 = wr_cnt[1];
    tick_once();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (mem_addr !== 4'd1 || busy !== 1'b1 || mem_we !== 1'b0)
      $display("FAIL mid_calc got %h/%b/%b want 1/1/0",
               mem_addr, busy, mem_we);
    else passed++;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || mem_addr !== 4'd0)
      $display("FAIL mid_abort got %b/%b/%h want 0/0/0",
               mem_we, busy, mem_addr);
    else passed++;
    checks++;
    if (mem_wdata !== 8'd0 || overrun !== 1'b0 || bcd_err !== 1'b0
        || day_pulse !== 1'b0)
      $display("FAIL mid_outs got %h/%b/%b/%b want 00/0/0/0",
               mem_wdata, overrun, bcd_err, day_pulse);
    else passed++;
    repeat (6) @(negedge clk);
    checks++;
    if (ram[0] !== 8'h00 || ram[1] !== 8'h59 || wr_cnt[1] - w1 !== 0)
      $display("FAIL mid_ram got %h:%h/%0d want 59:00/0",
               ram[1], ram[0], wr_cnt[1] - w1);
    else passed++;
    checks++;
    if (we2_cnt !== 0)
      $display("FAIL we_consecutive got %0d want 0", we2_cnt);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) wr_cnt[i] = 0;
    test_reset();
    test_seconds();
    test_min_carry();
    test_day_wrap();
    test_bcd_err();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rtc_time_updater.md
# rtc_time_updater

Sequencing client of the RTC register-file RAM: on each 1 Hz tick it reads the BCD time registers out of the RAM, increments them with carry, and writes them back. It sits on the RAM's read/write side, driving `address`, `data` and `we`, and consuming the RAM's registered `data_out`.

## Interface
Parameters:
- `ADDR_WIDTH`, 4: RAM address width.
- `DATA_WIDTH`, 8: RAM data width. Fixed at 8 for packed BCD.
- `BASE_ADDR`, 0: address of the seconds register.
  - minutes are at `BASE_ADDR+1`.
  - hours are at `BASE_ADDR+2`.
  - weekday is at `BASE_ADDR+3`.

Ports:
- `clk`  in  1  sole clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tick_1hz`  in  1  single-cycle pulse that requests one-second advance.
- `mem_addr`  out  ADDR_WIDTH  RAM address.
- `mem_wdata`  out  DATA_WIDTH  RAM write data.
- `mem_we`  out  1  RAM write enable; 1 = write, 0 = read.
- `mem_rdata`  in  DATA_WIDTH  RAM registered read data.
- `busy`  out  1  update sequence in progress.
- `day_pulse`  out  1  one-cycle pulse on 23:59:59 → 00:00:00.
- `overrun`  out  1  sticky flag: a tick was lost.
- `bcd_err`  out  1  sticky flag: an illegal BCD value was read and repaired.

## Operation
- All outputs are registered. Reset values: `mem_addr`=BASE_ADDR; `mem_wdata`, `mem_we`, `busy`, `day_pulse`, `overrun`, `bcd_err` = 0.
- RAM contract:
  - Read: address held with `we`=0 in cycle c; `mem_rdata` is valid in cycle c+1.
  - Write: `we`=1 in cycle c commits at the end of cycle c.
- FSM states: IDLE, READ, CALC, WRITE, NEXT.
  - IDLE: on a tick or a pending tick → READ with idx=0; `busy`=1.
  - READ: drive `mem_addr`=BASE_ADDR+idx, `mem_we`=0.
  - CALC: capture `mem_rdata` and compute the new value plus carry.
  - WRITE: drive the same address, `mem_we`=1, `mem_wdata`=new value.
  - NEXT: if carry and idx < last → READ with idx+1; otherwise → IDLE and `busy`=0.
- Per-register limits (packed BCD):
  - seconds: 00–59.
  - minutes: 00–59.
  - hours: 00–23.
  - weekday: 1–7 (only with `RTC_WEEKDAY_EN`).
- Increment rule:
  - If the low nibble is 9, it becomes 0 and the high nibble increments; otherwise the low nibble increments.
  - At the limit, write the minimum value and set carry.
- Illegal input (either nibble > 9, or value > limit, or weekday 0): write the minimum value, no carry, set `bcd_err`.
- `day_pulse` asserts for exactly one cycle, in the WRITE cycle of the hours register, when it wraps 23 → 00.
- Tick while `busy`:
  - Set a one-deep pending flag; serviced on return to IDLE, with no idle gap (IDLE → READ directly).
  - A tick while pending is already set is dropped and sets `overrun`.
- `overrun` and `bcd_err` clear only on `reset`.
- `reset` mid-sequence: immediately abort to IDLE, deassert `mem_we`, clear pending. A partially carried time is left as is in the RAM.

## Timing
- Tick at cycle t → READ at t+1. Each register costs 4 cycles (READ, CALC, WRITE, NEXT).
- Seconds-only update: `busy` high for cycles t+1..t+4; the write occurs at t+3.
- Full carry through hours: 12 cycles, or 16 with weekday.
- `mem_we` is high only in WRITE states, never for two consecutive cycles.
- The address is stable from READ through WRITE.

## Configuration
- `RTC_WEEKDAY_EN` defined:
  - hours wrap carries into the weekday register.
  - weekday runs 1..7, and 7 → 1.
  - last idx = 3.
- Not defined:
  - hours wrap ends the sequence, and address BASE_ADDR+3 is never accessed.
  - last idx = 2.
  - `day_pulse` behaves identically in both builds.

## Test plan
- RAM preloaded sec=0x08; one tick → single write of 0x09 to addr 0; `busy` high for 4 cycles; no access to addr 1.
- sec=0x59, min=0x09 → writes 0x00 to addr 0, then 0x10 to addr 1; sequence ends.
- 0x23:0x59:0x59 with weekday=0x07, `RTC_WEEKDAY_EN` defined → time becomes 00:00:00, weekday=0x01; `day_pulse` high for one cycle. Same stimulus without the macro → addr 3 untouched.
- sec=0x5A → writes 0x00, `bcd_err`=1, minutes not read.
- Ticks at t, t+1 and t+2 during a full-carry sequence → second tick serviced right after the first sequence; third tick dropped with `overrun`=1.
- `reset` asserted in the CALC cycle of minutes → next cycle `mem_we`=0 and `busy`=0; minutes not written; all outputs at their reset values.
